// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file constants and clear-sequencer state encodings
package mips_pkg;
    localparam int REG_COUNT = 32;
    localparam int ZERO_REG = 0;
    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;
endpackage

// File: rtl/register_file_clear_seq.sv
// register_file_clear_seq: after reset, walks registers 1..2**ADDR_WIDTH-1 writing zero, one per clock
module register_file_clear_seq
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_idx
);
    rf_state_e state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_CLEAR;
            ptr   <= ADDR_WIDTH'(1);
        end else begin
            state <= state_nxt;
            if (state == RF_CLEAR && ptr != '1) ptr <= ptr + ADDR_WIDTH'(1);
        end
    end
    // Leave CLEAR on the edge that clears the last index, so ptr never wraps
    always_comb begin
        state_nxt = (state == RF_CLEAR && ptr == '1) ? RF_IDLE : state;
    end
    assign busy    = state == RF_CLEAR;
    assign clr_en  = busy && !reset;
    assign clr_idx = ptr;
endmodule

// File: rtl/register_file.sv
// register_file: 2-read/1-write register file with post-reset clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  busy
);
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);
    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic clr_en, wr_en;
    register_file_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );
    assign wr_en = regWrite && !busy && writeReg != ZERO;
    always_ff @(posedge clk) begin
        if (clr_en) regs[clr_idx] <= '0;
        else if (wr_en && !reset) regs[writeReg] <= writeData;
    end
    // Index 0 is hardwired to zero regardless of array contents
    assign rd1 = readReg1 == ZERO ? '0 : regs[readReg1];
    assign rd2 = readReg2 == ZERO ? '0 : regs[readReg2];
`ifdef REGFILE_BYPASS_EN
    assign readData1 = busy ? '0 : (wr_en && writeReg == readReg1) ? writeData : rd1;
    assign readData2 = busy ? '0 : (wr_en && writeReg == readReg2) ? writeData : rd2;
`else
    assign readData1 = busy ? '0 : rd1;
    assign readData2 = busy ? '0 : rd2;
`endif
endmodule
